// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg: line/word types and arbiter state encodings shared by the L2 arbiter slice
package l2_arbiter_pkg;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;
  typedef logic [ADDR_W-1:0] lc3b_word;
  typedef logic [LINE_W-1:0] lc3b_cache_line;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} lc3b_arb_state;
  typedef enum logic {GRANT_I, GRANT_D} lc3b_arb_grant;
endpackage

// File: rtl/l2_arbiter_if.sv
// l2_arbiter_if: I-cache, D-cache and L2 line-port signals seen by the arbiter
interface l2_arbiter_if;
  import l2_arbiter_pkg::*;
  logic imem_read;
  lc3b_word imem_address;
  lc3b_cache_line imem_rdata;
  logic imem_resp;
  logic dmem_read;
  logic dmem_write;
  lc3b_word dmem_address;
  lc3b_cache_line dmem_wdata;
  lc3b_cache_line dmem_rdata;
  logic dmem_resp;
  logic l2_read;
  logic l2_write;
  lc3b_word l2_address;
  lc3b_cache_line l2_wdata;
  lc3b_cache_line l2_rdata;
  logic l2_resp;
  modport master (
    input imem_read, imem_address, dmem_read, dmem_write, dmem_address, dmem_wdata, l2_rdata, l2_resp,
    output imem_rdata, imem_resp, dmem_rdata, dmem_resp, l2_read, l2_write, l2_address, l2_wdata
  );
  modport slave (
    output imem_read, imem_address, dmem_read, dmem_write, dmem_address, dmem_wdata, l2_rdata, l2_resp,
    input imem_rdata, imem_resp, dmem_rdata, dmem_resp, l2_read, l2_write, l2_address, l2_wdata
  );
endinterface

// File: rtl/l2_arbiter_register.sv
// register: loadable storage, cleared asynchronously by rst_n
module register #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] in,
  output logic [width-1:0] out
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) out <= '0;
    else if (load) out <= in;
endmodule

// File: rtl/l2_arbiter.sv
// l2_arbiter: round-robin merge of I-cache and D-cache line requests onto one L2 port
module l2_arbiter
  import l2_arbiter_pkg::*;
(
  input logic clk,
  input logic rst_n,
  l2_arbiter_if.master bus
);
  lc3b_arb_state state_q, state_d;
  lc3b_arb_grant last_q, last_d;
  logic wr_q, wr_d;
  logic i_req, d_req, gnt_i, gnt_d, load, serving;
  assign i_req = bus.imem_read;
  assign d_req = bus.dmem_read | bus.dmem_write;
  // on a tie the client that did not win last time goes first
  assign gnt_d = state_q == IDLE && d_req && (!i_req || last_q == GRANT_I);
  assign gnt_i = state_q == IDLE && i_req && !gnt_d;
  assign load = gnt_i | gnt_d;
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    wr_d = wr_q;
    unique case (state_q)
      IDLE: if (load) begin
        state_d = gnt_d ? SERVE_D : SERVE_I;
        last_d = gnt_d ? GRANT_D : GRANT_I;
        wr_d = gnt_d & bus.dmem_write;
      end
      SERVE_I, SERVE_D: state_d = bus.l2_resp ? DONE : state_q;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= GRANT_I;
      wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      wr_q <= wr_d;
    end
  // L2 side is driven only from held state, never from live client inputs
  assign serving = state_q == SERVE_I || state_q == SERVE_D;
  assign bus.l2_read = serving && !wr_q;
  assign bus.l2_write = serving && wr_q;
  assign bus.imem_resp = state_q == SERVE_I && bus.l2_resp;
  assign bus.dmem_resp = state_q == SERVE_D && bus.l2_resp;
  assign bus.imem_rdata = bus.l2_rdata;
  assign bus.dmem_rdata = bus.l2_rdata;
  register #(.width(ADDR_W)) addr_reg (
    .clk(clk), .rst_n(rst_n), .load(load),
    .in(gnt_d ? bus.dmem_address : bus.imem_address), .out(bus.l2_address)
  );
  register #(.width(LINE_W)) wdata_reg (
    .clk(clk), .rst_n(rst_n), .load(gnt_d), .in(bus.dmem_wdata), .out(bus.l2_wdata)
  );
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed and randomized client traffic against a line-memory reference and scoreboard
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  l2_arbiter_if bus();
  l2_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {logic d; logic wr; lc3b_word a; lc3b_cache_line wd; lc3b_cache_line rd;} txn_t;
  txn_t q[$];
  lc3b_cache_line ref_mem [lc3b_word];
  lc3b_cache_line l2_mem [lc3b_word];
  int n_chk = 0, n_pass = 0, n_tmo = 0, lat_fixed = 0, cnt = 0, cur_lat = 0;
  logic spur = 0, fire;
  logic busy = 0, dead = 0, last_d = 0, pi = 0, pd = 0, pdw = 0;
  lc3b_word pia, pda;
  lc3b_cache_line pdwd;

  function automatic lc3b_cache_line line_of(lc3b_word a);
    return {16{a[7:0] ^ 8'h95}};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // L2 memory: answers each request after cur_lat extra cycles
  always begin
    @(posedge clk);
    #2;
    fire = 0;
    if (bus.l2_read || bus.l2_write) begin
      if (cnt >= cur_lat) begin
        fire = 1;
        cnt = 0;
      end else cnt++;
    end else begin
      cnt = 0;
      cur_lat = lat_fixed < 0 ? int'($urandom_range(0, 3)) : lat_fixed;
    end
    bus.l2_rdata = (fire && bus.l2_read) ?
      (l2_mem.exists(bus.l2_address) ? l2_mem[bus.l2_address] : line_of(bus.l2_address)) :
      {$urandom, $urandom, $urandom, $urandom};
    if (fire && bus.l2_write) l2_mem[bus.l2_address] = bus.l2_wdata;
    bus.l2_resp = fire || spur;
  end

  // reference: requests seen in an idle cycle are granted next cycle, ties alternate
  always @(negedge clk) begin
    logic was_dead, ei, ed;
    txn_t t;
    if (!rst_n) begin
      chk("rst_l2_req", {126'd0, bus.l2_read, bus.l2_write}, 0);
      chk("rst_resp", {126'd0, bus.imem_resp, bus.dmem_resp}, 0);
      chk("rst_l2_address", {112'd0, bus.l2_address}, 0);
      chk("rst_l2_wdata", bus.l2_wdata, 0);
      busy = 0; dead = 0; last_d = 0; pi = 0; pd = 0;
      q.delete();
    end else begin
      was_dead = dead; dead = 0; ei = 0; ed = 0;
      if (!busy && (pi || pd)) begin
        t.d = pd && (!pi || !last_d);
        t.wr = t.d && pdw;
        t.a = t.d ? pda : pia;
        t.wd = pdwd;
        t.rd = ref_mem.exists(t.a) ? ref_mem[t.a] : line_of(t.a);
        q.push_back(t);
        last_d = t.d;
        busy = 1;
      end
      if (busy) begin
        t = q[0];
        chk("l2_op", {126'd0, bus.l2_read, bus.l2_write}, t.wr ? 128'd1 : 128'd2);
        chk("l2_address", {112'd0, bus.l2_address}, {112'd0, t.a});
        if (t.wr) chk("l2_wdata", bus.l2_wdata, t.wd);
        if (bus.l2_resp) begin
          ei = !t.d; ed = t.d;
          if (t.wr) ref_mem[t.a] = t.wd;
          else if (t.d) chk("dmem_rdata", bus.dmem_rdata, t.rd);
          else chk("imem_rdata", bus.imem_rdata, t.rd);
          void'(q.pop_front());
          busy = 0; dead = 1;
        end
      end else chk("l2_idle", {126'd0, bus.l2_read, bus.l2_write}, 0);
      chk("imem_resp", {127'd0, bus.imem_resp}, {127'd0, ei});
      chk("dmem_resp", {127'd0, bus.dmem_resp}, {127'd0, ed});
      pi = bus.imem_read && !busy && !dead && !was_dead;
      pd = (bus.dmem_read || bus.dmem_write) && !busy && !dead && !was_dead;
      pdw = bus.dmem_write; pia = bus.imem_address; pda = bus.dmem_address; pdwd = bus.dmem_wdata;
    end
  end

  task automatic wait_resp(input logic d);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(d ? bus.dmem_resp : bus.imem_resp) && t < 200);
    if (!(d ? bus.dmem_resp : bus.imem_resp)) begin
      $display("FAIL resp_timeout: client %0d got no resp within %0d cycles", d, t);
      n_tmo++;
    end
  endtask

  task automatic do_req(input logic d, input logic wr, input lc3b_word a, input lc3b_cache_line wd);
    @(posedge clk);
    #1;
    if (d) begin
      bus.dmem_read = !wr; bus.dmem_write = wr; bus.dmem_address = a; bus.dmem_wdata = wd;
    end else begin
      bus.imem_read = 1; bus.imem_address = a;
    end
    wait_resp(d);
    @(posedge clk);
    #1;
    if (d) {bus.dmem_read, bus.dmem_write} = 2'b00;
    else bus.imem_read = 0;
  endtask

  initial begin
    {bus.imem_read, bus.dmem_read, bus.dmem_write} = 3'b000;
    bus.imem_address = 0; bus.dmem_address = 0; bus.dmem_wdata = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    repeat (3) @(posedge clk);
    lat_fixed = 3;
    do_req(0, 0, 16'h1230, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    fork
      do_req(0, 0, 16'h1240, 0);
      do_req(1, 1, 16'h4440, {16{8'h11}});
    join
    lat_fixed = 1;
    fork
      repeat (2) do_req(0, 0, 16'h1250, 0);
      repeat (2) do_req(1, 0, 16'h8010, 0);
    join
    lat_fixed = 4;
    @(posedge clk);
    #1 bus.dmem_read = 1; bus.dmem_address = 16'h2000;
    repeat (2) @(posedge clk);
    #1 bus.dmem_address = 16'h3000;
    wait_resp(1);
    @(posedge clk);
    #1 bus.dmem_read = 0;
    lat_fixed = 10;
    @(posedge clk);
    #1 bus.dmem_write = 1; bus.dmem_address = 16'h5000; bus.dmem_wdata = {4{32'hDEADBEEF}};
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #4 rst_n = 1; bus.dmem_write = 0;
    @(posedge clk);
    #1 spur = 1;
    @(posedge clk);
    #1 spur = 0;
    lat_fixed = -1;
    fork
      repeat (20) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_req(0, 0, 16'h1000 + (16'($urandom_range(0, 7)) << 4), 0);
      end
      repeat (20) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        do_req(1, 1'($urandom_range(0, 1)), 16'h8000 + (16'($urandom_range(0, 3)) << 4),
               {$urandom, $urandom, $urandom, $urandom});
      end
    join
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk + n_tmo);
    $finish;
  end
endmodule
